syscall_unit: RTL and testbench

- Responder for the decoder's syscall indication. When the control decoder flags a SYSCALL, this block stalls the PC and samples $v0 and $a0 from the register file.
- It then services the call: halt, display an integer, or ignore unknown codes.
- It sits beside the PC/register-file path and drives the PC stall, the halt indicator and the LED display register.

---
 rtl/syscall_unit.sv | 108 ++++++++++
 tb/tb_syscall_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/syscall_unit.sv
// Syscall responder: stalls the PC, samples $v0/$a0 and services halt/display calls.
// Optional early PAUSE exit through in_go when SYSCALL_GO_EN is defined.
module syscall_unit #(
    parameter int unsigned PAUSE_CYCLES = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_syscall,
    input  logic             in_valid,
    input  logic [31:0]      in_v0,
    input  logic [31:0]      in_a0,
`ifdef SYSCALL_GO_EN
    input  logic             in_go,
`endif
    output logic             out_stall,
    output logic             out_halted,
    output logic [31:0]      out_led,
    output logic             out_led_upd,
    output logic [CNT_W-1:0] out_count
);

    // The pause counter only ever holds PAUSE_CYCLES-1 down to 0.
    localparam int unsigned PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PW-1:0] PauseLoad = (PAUSE_CYCLES > 0) ? PW'(PAUSE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        StIdle,
        StDispatch,
        StPause,
        StDone,
        StHalted
    } state_e;

    state_e        state_q;
    logic [31:0]   v0_q;
    logic [31:0]   a0_q;
    logic [PW-1:0] pause_cnt_q;
    logic          trig;
    logic          go;

`ifdef SYSCALL_GO_EN
    assign go = in_go;
`else
    assign go = 1'b0;
`endif

    assign trig      = in_syscall & in_valid;
    assign out_stall = ((state_q != StIdle) && (state_q != StDone)) ||
                       ((state_q == StIdle) && trig);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= StIdle;
            v0_q        <= '0;
            a0_q        <= '0;
            pause_cnt_q <= '0;
            out_halted  <= 1'b0;
            out_led     <= '0;
            out_led_upd <= 1'b0;
            out_count   <= '0;
        end else begin
            out_led_upd <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trig) begin
                        v0_q    <= in_v0;
                        a0_q    <= in_a0;
                        state_q <= StDispatch;
                        if (out_count != '1) begin
                            out_count <= out_count + 1'b1;
                        end
                    end
                end
                StDispatch: begin
                    if (v0_q == 32'd10) begin
                        state_q    <= StHalted;
                        out_halted <= 1'b1;
                    end else if ((v0_q == 32'd34) || (v0_q == 32'd1)) begin
                        out_led     <= a0_q;
                        out_led_upd <= 1'b1;
                        if (PAUSE_CYCLES > 0) begin
                            state_q     <= StPause;
                            pause_cnt_q <= PauseLoad;
                        end else begin
                            state_q <= StDone;
                        end
                    end else begin
                        state_q <= StDone;
                    end
                end
                StPause: begin
                    // Resume request wins over the remaining count.
                    if (go || (pause_cnt_q == '0)) begin
                        state_q <= StDone;
                    end else begin
                        pause_cnt_q <= pause_cnt_q - 1'b1;
                    end
                end
                // Releasing the stall for one cycle lets the PC step past the syscall.
                StDone:   state_q <= StIdle;
                StHalted: state_q <= StHalted;
                default:  state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: main instance with defaults plus a CNT_W=4,
// PAUSE_CYCLES=0 instance for counter saturation.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        rst, syscall, valid, go;
    logic [31:0] v0, a0;
    logic        stall, halted, led_upd;
    logic [31:0] led;
    logic [15:0] count;

    logic        s_rst, s_syscall, s_valid;
    logic [31:0] s_v0, s_a0;
    logic        s_stall, s_halted, s_led_upd;
    logic [31:0] s_led;
    logic [3:0]  s_count;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned upd_seen = 0;
    logic [31:0] led_q[$];

    always #5 clk = ~clk;

    syscall_unit dut (
        .in_clk     (clk),
        .in_rst     (rst),
        .in_syscall (syscall),
        .in_valid   (valid),
        .in_v0      (v0),
        .in_a0      (a0),
`ifdef SYSCALL_GO_EN
        .in_go      (go),
`endif
        .out_stall  (stall),
        .out_halted (halted),
        .out_led    (led),
        .out_led_upd(led_upd),
        .out_count  (count)
    );

    syscall_unit #(.PAUSE_CYCLES(0), .CNT_W(4)) dut_sat (
        .in_clk     (clk),
        .in_rst     (s_rst),
        .in_syscall (s_syscall),
        .in_valid   (s_valid),
        .in_v0      (s_v0),
        .in_a0      (s_a0),
`ifdef SYSCALL_GO_EN
        .in_go      (1'b0),
`endif
        .out_stall  (s_stall),
        .out_halted (s_halted),
        .out_led    (s_led),
        .out_led_upd(s_led_upd),
        .out_count  (s_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard: every display pulse must match the next queued a0.
    always @(negedge clk) begin
        if (led_upd === 1'b1) begin
            upd_seen++;
            if (led_q.size() == 0) chk("led_sb_underflow", led_q.size(), 1);
            else chk("led_sb", led, led_q.pop_front());
        end
    end

    initial begin
        int n;
        logic bad;
        rst = 1'b1; syscall = 1'b0; valid = 1'b0; go = 1'b0; v0 = '0; a0 = '0;
        s_rst = 1'b1; s_syscall = 1'b0; s_valid = 1'b0; s_v0 = '0; s_a0 = '0;
        repeat (2) step();
        rst = 1'b0; s_rst = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_halted", halted, 0);
        chk("rst_led", led, 0);
        chk("rst_upd", led_upd, 0);
        chk("rst_count", count, 0);

        // syscall without valid is ignored
        bad = 1'b0;
        syscall = 1'b1; v0 = 32'd10;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            if (stall !== 1'b0) bad = 1'b1;
        end
        chk("novalid_stall", bad, 0);
        chk("novalid_count", count, 0);

        // display call, held syscall, full PAUSE
        step();
        valid = 1'b1; v0 = 32'd34; a0 = 32'h0000_ABCD; led_q.push_back(32'h0000_ABCD);
        #1;
        chk("disp_trig_stall", stall, 1);
        n = 1;
        while (n < 60) begin
            step(); #1;
            if (stall !== 1'b1) break;
            n++;
        end
        chk("disp_stall_cycles", n, 18);
        chk("disp_count", count, 1);
        chk("disp_led", led, 32'h0000_ABCD);
        chk("disp_upd_pulses", upd_seen, 1);
        syscall = 1'b0;
        step(); #1;
        chk("disp_idle_stall", stall, 0);

        // unknown code: stall released in DONE even with syscall still high
        syscall = 1'b1; v0 = 32'd5; a0 = 32'h1234;
        #1;
        chk("unk_trig_stall", stall, 1);
        step(); #1;
        chk("unk_dispatch_stall", stall, 1);
        step(); #1;
        chk("unk_done_stall", stall, 0);
        chk("unk_count", count, 2);
        chk("unk_led_hold", led, 32'h0000_ABCD);
        syscall = 1'b0;
        step(); #1;
        chk("unk_no_retrig", stall, 0);
        chk("unk_count_after", count, 2);

        // halt persists, ignores further syscalls
        syscall = 1'b1; v0 = 32'd10;
        step(); step();
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            syscall = i[0]; v0 = 32'd5;
            #1;
            if (halted !== 1'b1 || stall !== 1'b1) bad = 1'b1;
        end
        chk("halt_persist", bad, 0);
        chk("halt_count", count, 3);
        syscall = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("hrst_stall", stall, 0);
        chk("hrst_halted", halted, 0);
        chk("hrst_led", led, 0);
        chk("hrst_upd", led_upd, 0);
        chk("hrst_count", count, 0);

`ifdef SYSCALL_GO_EN
        // early exit from PAUSE on the third PAUSE cycle
        step();
        syscall = 1'b1; v0 = 32'd1; a0 = 32'd7; led_q.push_back(32'd7);
        repeat (4) step();
        syscall = 1'b0; go = 1'b1;
        #1;
        chk("go_pause_stall", stall, 1);
        step();
        go = 1'b0;
        #1;
        chk("go_done_stall", stall, 0);
        chk("go_led", led, 7);
`endif

        // saturation on the CNT_W=4, PAUSE_CYCLES=0 instance
        for (int i = 1; i <= 16; i++) begin
            step();
            s_syscall = 1'b1; s_valid = 1'b1; s_v0 = 32'd1; s_a0 = i;
            step();
            step(); #1;
            if (i == 15) chk("sat_count15", s_count, 15);
            if (i == 16) chk("sat_done_stall", s_stall, 0);
            s_syscall = 1'b0;
        end
        chk("sat_count16", s_count, 15);
        chk("sat_led", s_led, 16);

        step();
        chk("led_sb_drained", led_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
